// File: rtl/prs_pkg.sv
// prs_pkg: PRBS-15 constants, checker FSM state type and LFSR step function shared with prs_gen
package prs_pkg;
    localparam int PRS_LEN = 15;
    localparam logic [PRS_LEN-1:0] PRS_TAPS = 15'h6000;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } prs_state_t;

    function automatic logic [PRS_LEN-1:0] prs_next(input logic [PRS_LEN-1:0] s);
        return {s[PRS_LEN-2:0], ^(s & PRS_TAPS)};
    endfunction
endpackage

// File: rtl/prs_lfsr_sync.sv
// prs_lfsr_sync: 15-bit PRBS replica that either loads received bits or free-runs on its own feedback
module prs_lfsr_sync
    import prs_pkg::*;
(
    input  logic CLK,
    input  logic nRESET,
    input  logic i_en,
    input  logic i_load,
    input  logic i_bit,
    output logic o_p,
    output logic o_zero
);
    logic [PRS_LEN-1:0] s, s_free, s_d;

    assign s_free = prs_next(s);
    assign o_p    = s_free[0];
    assign s_d    = i_load ? {s[PRS_LEN-2:0], i_bit} : s_free;
    assign o_zero = s_d == '0;

    // replica register advances once per valid bit
    always_ff @(posedge CLK) begin
        if (!nRESET) s <= '0;
        else if (i_en) s <= s_d;
    end
endmodule

// File: rtl/prs_ber_checker.sv
// prs_ber_checker: self-synchronising PRBS-15 bit-error checker; define PRS_BER_TOTAL_EN for running totals
module prs_ber_checker
    import prs_pkg::*;
#(
    parameter int WIN_LEN  = 10000,
    parameter int CNT_W    = 16,
    parameter int SYNC_LEN = 64,
    parameter int TOT_W    = 32
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic             i_vld,
    input  logic             i_sym,
    input  logic [CNT_W-1:0] i_loss_thr,
    output logic             o_locked,
    output logic             o_err,
    output logic             o_win_stb,
    output logic [CNT_W-1:0] o_win_errs,
    output logic [1:0]       o_state
`ifdef PRS_BER_TOTAL_EN
    ,
    output logic [TOT_W-1:0] o_tot_bits,
    output logic [TOT_W-1:0] o_tot_errs
`endif
);
    localparam int MW = $clog2(SYNC_LEN + 1);

    prs_state_t       state, state_d;
    logic [3:0]       load_cnt;
    logic [MW-1:0]    match_cnt;
    logic [CNT_W-1:0] win_bits, win_errs, bits_n, errs_n;
    logic             p, zero_d, mis, load_done, sync_done, win_end, loss;

    prs_lfsr_sync u_lfsr (
        .CLK    (CLK),
        .nRESET (nRESET),
        .i_en   (i_vld),
        .i_load (state == ST_SEARCH),
        .i_bit  (i_sym),
        .o_p    (p),
        .o_zero (zero_d)
    );

    assign mis       = i_sym ^ p;
    assign load_done = load_cnt == 4'(PRS_LEN - 1);
    assign sync_done = match_cnt == MW'(SYNC_LEN - 1);
    assign bits_n    = win_bits + 1'b1;
    assign errs_n    = (mis && win_errs != '1) ? win_errs + 1'b1 : win_errs;
    assign win_end   = bits_n == CNT_W'(WIN_LEN);
    assign loss      = i_loss_thr != '0 && errs_n >= i_loss_thr;
    assign o_state   = state;
    assign o_locked  = state == ST_LOCKED;

    // state register
    always_ff @(posedge CLK) begin
        if (!nRESET) state <= ST_SEARCH;
        else state <= state_d;
    end

    // next state: only valid bits move the FSM, the illegal encoding falls back to SEARCH
    always_comb begin
        state_d = ST_SEARCH;
        case (state)
            ST_SEARCH: state_d = (i_vld && load_done && !zero_d) ? ST_VERIFY : ST_SEARCH;
            ST_VERIFY: state_d = !i_vld ? ST_VERIFY : mis ? ST_SEARCH : sync_done ? ST_LOCKED : ST_VERIFY;
            ST_LOCKED: state_d = (i_vld && loss) ? ST_SEARCH : ST_LOCKED;
            default:   state_d = ST_SEARCH;
        endcase
    end

    // sync counters, window counters and the registered error/window pulses
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            load_cnt   <= '0;
            match_cnt  <= '0;
            win_bits   <= '0;
            win_errs   <= '0;
            o_err      <= 1'b0;
            o_win_stb  <= 1'b0;
            o_win_errs <= '0;
        end else begin
            o_err     <= 1'b0;
            o_win_stb <= 1'b0;
            if (i_vld) begin
                case (state)
                    ST_SEARCH: begin
                        load_cnt  <= load_done ? 4'd0 : load_cnt + 4'd1;
                        match_cnt <= '0;
                    end
                    ST_VERIFY: begin
                        load_cnt  <= '0;
                        match_cnt <= match_cnt + 1'b1;
                        win_bits  <= '0;
                        win_errs  <= '0;
                    end
                    ST_LOCKED: begin
                        o_err    <= mis;
                        win_bits <= (win_end || loss) ? '0 : bits_n;
                        win_errs <= (win_end || loss) ? '0 : errs_n;
                        if (win_end) begin
                            o_win_stb  <= 1'b1;
                            o_win_errs <= errs_n;
                        end
                    end
                    default: load_cnt <= '0;
                endcase
            end
        end
    end

`ifdef PRS_BER_TOTAL_EN
    // saturating totals of every bit compared while locked; loss of lock leaves them alone
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            o_tot_bits <= '0;
            o_tot_errs <= '0;
        end else if (i_vld && state == ST_LOCKED) begin
            o_tot_bits <= (o_tot_bits != '1) ? o_tot_bits + 1'b1 : o_tot_bits;
            o_tot_errs <= (mis && o_tot_errs != '1) ? o_tot_errs + 1'b1 : o_tot_errs;
        end
    end
`endif
endmodule

// File: tb/tb_prs_ber_checker.sv
// tb_prs_ber_checker: directed PRBS-15 scenarios checked cycle by cycle against a sequence-level model
module tb_prs_ber_checker;
    localparam int WIN_LEN  = 10000;
    localparam int SYNC_LEN = 64;

    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        i_vld = 1'b0;
    logic        i_sym = 1'b0;
    logic [15:0] i_loss_thr = '0;
    logic        o_locked, o_err, o_win_stb;
    logic [15:0] o_win_errs;
    logic [1:0]  o_state;
`ifdef PRS_BER_TOTAL_EN
    logic [31:0] o_tot_bits, o_tot_errs;
`endif

    prs_ber_checker #(.WIN_LEN(WIN_LEN), .CNT_W(16), .SYNC_LEN(SYNC_LEN), .TOT_W(32)) dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .i_vld      (i_vld),
        .i_sym      (i_sym),
        .i_loss_thr (i_loss_thr),
        .o_locked   (o_locked),
        .o_err      (o_err),
        .o_win_stb  (o_win_stb),
        .o_win_errs (o_win_errs),
        .o_state    (o_state)
`ifdef PRS_BER_TOTAL_EN
        ,
        .o_tot_bits (o_tot_bits),
        .o_tot_errs (o_tot_errs)
`endif
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int nstb = 0;
    int nerr = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            if (bad <= 20) $display("FAIL %s got=%0h want=%0h", n, a, e);
        end
    endtask

    // model: the replica is kept as a bit history following b[n] = b[n-15] ^ b[n-14]
    bit          hist[$];
    int          mode = 0;
    int          nload = 0;
    int          nmatch = 0;
    int          wbits = 0;
    int          werrs = 0;
    logic        e_err = 1'b0;
    logic        e_stb = 1'b0;
    logic [15:0] e_werrs = '0;
    logic [31:0] tbits = '0;
    logic [31:0] terrs = '0;
    logic [15:0] thr = '0;
    logic [14:0] g = 15'h7ace;

    task automatic m_reset();
        hist = {};
        repeat (15) hist.push_back(1'b0);
        mode = 0; nload = 0; nmatch = 0; wbits = 0; werrs = 0;
        e_err = 1'b0; e_stb = 1'b0; e_werrs = '0; tbits = '0; terrs = '0;
    endtask

    task automatic m_bit(input bit b);
        bit pr, nz, loss;
        pr = hist[hist.size() - 15] ^ hist[hist.size() - 14];
        e_err = 1'b0;
        e_stb = 1'b0;
        if (mode == 0) begin
            hist.push_back(b);
            nload++;
            if (nload == 15) begin
                nload = 0;
                nz = 1'b0;
                for (int i = 1; i <= 15; i++) nz |= hist[hist.size() - i];
                if (nz) begin mode = 1; nmatch = 0; end
            end
        end else begin
            hist.push_back(pr);
            if (mode == 1) begin
                if (b != pr) begin
                    mode = 0; nload = 0;
                end else begin
                    nmatch++;
                    if (nmatch == SYNC_LEN) begin mode = 2; wbits = 0; werrs = 0; end
                end
            end else begin
                e_err = b != pr;
                wbits++;
                if (e_err && werrs < 65535) werrs++;
                if (tbits != 32'hffff_ffff) tbits++;
                if (e_err && terrs != 32'hffff_ffff) terrs++;
                if (wbits == WIN_LEN) begin e_stb = 1'b1; e_werrs = 16'(werrs); end
                loss = thr != 0 && werrs >= int'(thr);
                if (wbits == WIN_LEN || loss) begin wbits = 0; werrs = 0; end
                if (loss) begin mode = 0; nload = 0; end
            end
        end
        if (hist.size() > 40) void'(hist.pop_front());
    endtask

    task automatic drv(input bit v, input bit b, input bit r);
        @(negedge CLK);
        nRESET = r; i_vld = v; i_sym = b; i_loss_thr = thr;
        if (!r) m_reset();
        else if (v) m_bit(b);
        else begin e_err = 1'b0; e_stb = 1'b0; end
    endtask

    task automatic sendp(input bit f);
        bit nb;
        nb = g[14] ^ g[13];
        g = {g[13:0], nb};
        drv(1'b1, nb ^ f, 1'b1);
    endtask

    task automatic sparse(input int n);
        for (int k = 0; k < n; k++) begin
            sendp(1'b0);
            repeat (63) drv(1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic after();
        @(posedge CLK);
        #2;
    endtask

    // compare the DUT against the model one step after every clock edge
    always @(posedge CLK) begin
        #1;
        chk("state", 32'(o_state), 32'(mode));
        chk("locked", 32'(o_locked), 32'(mode == 2));
        chk("err", 32'(o_err), 32'(e_err));
        chk("win_stb", 32'(o_win_stb), 32'(e_stb));
        chk("win_errs", 32'(o_win_errs), 32'(e_werrs));
`ifdef PRS_BER_TOTAL_EN
        chk("tot_bits", o_tot_bits, tbits);
        chk("tot_errs", o_tot_errs, terrs);
`endif
        if (o_win_stb === 1'b1) nstb++;
        if (o_err === 1'b1) nerr++;
    end

    initial begin
        int e0;
        m_reset();
        // reset and clean lock: locked exactly at the 79th bit, one clean window
        drv(1'b0, 1'b0, 1'b0);
        after();
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_locked", 32'(o_locked), 32'd0);
        chk("rst_stb", 32'(o_win_stb), 32'd0);
        chk("rst_werrs", 32'(o_win_errs), 32'd0);
        repeat (78) sendp(1'b0);
        after();
        chk("prelock78", 32'(o_locked), 32'd0);
        sendp(1'b0);
        after();
        chk("lock79", 32'(o_state), 32'd2);
        repeat (WIN_LEN) sendp(1'b0);
        after();
        chk("win0_stb", 32'(o_win_stb), 32'd1);
        chk("win0_errs", 32'(o_win_errs), 32'd0);
        chk("win0_count", 32'(nstb), 32'd1);
        // every 500th bit flipped: 20 errors per window, lock held
        thr = 16'd1000;
        e0 = nerr;
        for (int k = 0; k < WIN_LEN; k++) sendp(k % 500 == 499);
        after();
        chk("flip_stb", 32'(o_win_stb), 32'd1);
        chk("flip_werrs", 32'(o_win_errs), 32'd20);
        chk("flip_pulses", 32'(nerr - e0), 32'd20);
        chk("flip_locked", 32'(o_locked), 32'd1);
        // mismatch at bit 30 while verifying: relock at bit 109, not before
        drv(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 30; k++) sendp(k == 30);
        after();
        chk("verify_drop", 32'(o_state), 32'd0);
        repeat (78) sendp(1'b0);
        after();
        chk("relock108", 32'(o_locked), 32'd0);
        sendp(1'b0);
        after();
        chk("relock109", 32'(o_locked), 32'd1);
        // burst of 8 errors with threshold 8: loss on the 8th, then relock
        thr = 16'd8;
        e0 = nstb;
        repeat (7) sendp(1'b1);
        after();
        chk("burst7", 32'(o_state), 32'd2);
        sendp(1'b1);
        after();
        chk("burst8", 32'(o_state), 32'd0);
        chk("burst_nostb", 32'(nstb - e0), 32'd0);
        thr = 16'd0;
        repeat (79) sendp(1'b0);
        after();
        chk("burst_relock", 32'(o_locked), 32'd1);
        // all-zero input never leaves SEARCH
        drv(1'b0, 1'b0, 1'b0);
        repeat (1000) drv(1'b1, 1'b0, 1'b1);
        after();
        chk("zeros_state", 32'(o_state), 32'd0);
        chk("zeros_locked", 32'(o_locked), 32'd0);
        // sparse valid bits, reset while locked, relock
        drv(1'b0, 1'b0, 1'b0);
        sparse(79);
        chk("sparse_lock", 32'(o_locked), 32'd1);
        sparse(20);
`ifdef PRS_BER_TOTAL_EN
        chk("tot_before", o_tot_bits, 32'd20);
`endif
        drv(1'b0, 1'b0, 1'b0);
        after();
        chk("mid_rst_state", 32'(o_state), 32'd0);
        chk("mid_rst_locked", 32'(o_locked), 32'd0);
        chk("mid_rst_werrs", 32'(o_win_errs), 32'd0);
`ifdef PRS_BER_TOTAL_EN
        chk("tot_rst", o_tot_bits, 32'd0);
`endif
        sparse(78);
        chk("sparse_pre", 32'(o_locked), 32'd0);
        sparse(1);
        chk("sparse_relock", 32'(o_locked), 32'd1);
        sparse(30);
`ifdef PRS_BER_TOTAL_EN
        chk("tot_bits30", o_tot_bits, 32'd30);
        chk("tot_errs0", o_tot_errs, 32'd0);
`endif
        drv(1'b0, 1'b0, 1'b1);
        after();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prs_ber_checker.md
Name: prs_ber_checker

Overview:
- Receive-side partner of prs_gen. Sits after fano_decoder on the decoded bit stream (o_vld/o_dec_sym).
- Self-synchronises a local PRBS-15 replica to incoming bits, then counts bit errors per fixed window.
- Reports lock status, per-window error count and a saturating total, for BER measurement in simulation and on hardware.

Parameters:
- WIN_LEN, 10000, bits per measurement window (≥ 2)
- CNT_W, 16, width of window bit/error counters (2^CNT_W > WIN_LEN)
- SYNC_LEN, 64, consecutive matching bits required in VERIFY before LOCKED
- TOT_W, 32, width of total error/bit counters

Ports:
- CLK  in  1  clock
- nRESET  in  1  reset, synchronous, active-low
- i_vld  in  1  input bit valid; gaps allowed
- i_sym  in  1  decoded bit
- i_loss_thr  in  CNT_W  errors within one window that force loss of lock
- o_locked  out  1  high in LOCKED state
- o_err  out  1  1-cycle pulse: compared bit mismatched (LOCKED only)
- o_win_stb  out  1  1-cycle pulse at window end
- o_win_errs  out  CNT_W  error count of last completed window, held until next o_win_stb
- o_state  out  2  FSM state, for debug

Behaviour:
- Reset: all outputs 0; FSM = SEARCH; LFSR = 0; all counters 0. Reset in any state returns there on the next edge.
- Polynomial (package constant): x^15+x^14+1. Predicted bit p = s[14]^s[13]. State shift is s <= {s[13:0], x}.
- All actions below occur only on cycles with i_vld=1. With i_vld=0, all state holds and pulses are 0.
- SEARCH:
  - s <= {s[13:0], i_sym}; load counter increments.
  - After 15 loaded bits: if s (including the new bit) != 0, go to VERIFY with match counter 0. Otherwise restart loading (counter = 0); never leave the all-zero lock-up state.
- VERIFY:
  - s <= {s[13:0], p} (free-run).
  - i_sym == p: match counter +1. On reaching SYNC_LEN → LOCKED; window bit/error counters cleared.
  - i_sym != p: → SEARCH, load counter 0.
- LOCKED:
  - s free-runs as in VERIFY.
  - Each bit: window bit counter +1.
  - Mismatch: o_err=1 on the next cycle (latency 1); window error counter +1, saturating at 2^CNT_W-1.
  - Bit count reaching WIN_LEN: o_win_stb=1 next cycle, o_win_errs <= final count (including the current bit); both window counters restart at 0.
  - Window error count (including the current bit) ≥ i_loss_thr and i_loss_thr != 0: → SEARCH next cycle; partial window discarded; no o_win_stb.
  - Loss and window-end on the same bit: loss wins, but o_win_stb still fires with that count.
- o_locked and o_state are registered and reflect the state after the edge.
- o_state encoding: SEARCH=0, VERIFY=1, LOCKED=2. Value 3 is illegal and recovers to SEARCH.

Optional Feature:
- Macro: PRS_BER_TOTAL_EN.
- Defined:
  - Adds ports o_tot_bits and o_tot_errs (TOT_W each).
  - Count all bits and errors compared in LOCKED since reset. Saturating; never cleared by loss of lock.
  - Updated 1 cycle after the compared bit.
- Undefined: ports and counters absent; the rest is unchanged.

Decomposition:
- Package prs_pkg:
  - PRS_LEN=15
  - PRS_TAPS (15'h6000)
  - state enum {ST_SEARCH, ST_VERIFY, ST_LOCKED}
  - function prs_next(s), shared with prs_gen.
- One natural sub-module: prs_lfsr_sync. Holds the 15-bit register with a load/free-run select and outputs p and a zero flag.
- FSM and counters stay in the top module.

Test Plan:
- Clean PRBS-15 from prs_gen, i_vld every cycle → o_locked rises 15+64=79 valid bits after first bit; each window o_win_errs=0, o_win_stb every 10000 valid bits.
- Locked, i_loss_thr=1000, flip every 500th bit → o_err pulses each flip 1 cycle later; o_win_errs=20 each window; stays locked.
- Flip one bit at bit 30 (VERIFY) → return to SEARCH; lock at bit 30+15+64 region, never earlier than bit 109.
- Locked, i_loss_thr=8, burst of 8 inverted bits → state SEARCH 1 cycle after 8th error; no o_win_stb; relock follows.
- All-zero input for 1000 bits → remains SEARCH, o_locked=0 throughout.
- i_vld 1-in-64 (as fano path) plus nRESET pulsed low mid-LOCKED → all outputs 0 next edge; relock after 79 valid bits; PRS_BER_TOTAL_EN build shows totals reset and then counting.
